// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter that shares one synchronous SRAM port between several cores.
// Each grant goes IDLE -> ISSUE -> [WAIT] -> DONE, and every output except stall is registered.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no access in flight; pick the next requester from ptr upward
//   ST_ISSUE | address/data on the pins; GW_n low for a write, OE_n low for a read
//   ST_WAIT  | read in flight; OE_n held low for READ_LATENCY cycles
//   ST_DONE  | one-cycle completion pulse to the granted core; advance ptr
module sram_port_arbiter #(
   parameter int NUM_CORES    = 4,
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic                          new_clock,
   input  logic                          reset_n,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [NUM_CORES-1:0]          we,
   input  logic [NUM_CORES*ADDR_W-1:0]   addr,
   input  logic [NUM_CORES*DATA_W-1:0]   wdata,
   output logic [NUM_CORES-1:0]          stall,
   output logic [NUM_CORES-1:0]          done,
   output logic [DATA_W-1:0]             rdata,
   output logic [$clog2(NUM_CORES)-1:0]  grant_id,
   output logic                          busy,
   output logic [ADDR_W-1:0]             sram_addr,
   output logic [DATA_W-1:0]             sram_wd,
   input  logic [DATA_W-1:0]             sram_rd,
   output logic                          sram_gw_n,
   output logic                          sram_oe_n
);

   localparam int GID_W = $clog2(NUM_CORES);
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [GID_W-1:0]     ptr_q, ptr_d;
   logic [GID_W-1:0]     grant_q, grant_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0]    sram_wd_q, sram_wd_d;
   logic                 sram_gw_n_q, sram_gw_n_d;
   logic                 sram_oe_n_q, sram_oe_n_d;
   logic                 busy_q, busy_d;
   logic [NUM_CORES-1:0] done_q, done_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 win_found;
   logic [GID_W-1:0]     win_id;

   // Scan from ptr upward with wrap; the first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!win_found && req[(int'(ptr_q) + i) % NUM_CORES]) begin
            win_found = 1'b1;
            win_id    = GID_W'((int'(ptr_q) + i) % NUM_CORES);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      we_d        = we_q;
      sram_addr_d = sram_addr_q;
      sram_wd_d   = sram_wd_q;
      sram_gw_n_d = 1'b1;
      sram_oe_n_d = 1'b1;
      done_d      = '0;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d     = ST_ISSUE;
               grant_d     = win_id;
               we_d        = we[win_id];
               sram_addr_d = addr[int'(win_id)*ADDR_W +: ADDR_W];
               sram_wd_d   = wdata[int'(win_id)*DATA_W +: DATA_W];
               sram_gw_n_d = ~we[win_id];
               sram_oe_n_d = we[win_id];
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d         = ST_DONE;
               done_d[grant_q] = 1'b1;
            end else begin
               state_d     = ST_WAIT;
               sram_oe_n_d = 1'b0;
               cnt_d       = CNT_W'(READ_LATENCY);
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d         = ST_DONE;
               rdata_d         = sram_rd;
               done_d[grant_q] = 1'b1;
            end else begin
               cnt_d       = cnt_q - 1'b1;
               sram_oe_n_d = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = (grant_q == GID_W'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge new_clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         we_q        <= 1'b0;
         sram_addr_q <= '0;
         sram_wd_q   <= '0;
         sram_gw_n_q <= 1'b1;
         sram_oe_n_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= '0;
         rdata_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         we_q        <= we_d;
         sram_addr_q <= sram_addr_d;
         sram_wd_q   <= sram_wd_d;
         sram_gw_n_q <= sram_gw_n_d;
         sram_oe_n_q <= sram_oe_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
      end
   end

   assign stall     = req & ~done_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign grant_id  = grant_q;
   assign busy      = busy_q;
   assign sram_addr = sram_addr_q;
   assign sram_wd   = sram_wd_q;
   assign sram_gw_n = sram_gw_n_q;
   assign sram_oe_n = sram_oe_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: an SSRAM read-latency model plus a completion scoreboard.
module tb_sram_port_arbiter;

   localparam int NC = 4;
   localparam int AW = 6;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NC-1:0]    req;
   logic [NC-1:0]    we;
   logic [NC*AW-1:0] addr;
   logic [NC*DW-1:0] wdata;
   logic [NC-1:0]    stall;
   logic [NC-1:0]    done;
   logic [DW-1:0]    rdata;
   logic [1:0]       grant_id;
   logic             busy;
   logic [AW-1:0]    sram_addr;
   logic [DW-1:0]    sram_wd;
   logic [DW-1:0]    sram_rd;
   logic             sram_gw_n;
   logic             sram_oe_n;

   sram_port_arbiter #(
      .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)
   ) dut (
      .new_clock(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
      .grant_id(grant_id), .busy(busy), .sram_addr(sram_addr),
      .sram_wd(sram_wd), .sram_rd(sram_rd), .sram_gw_n(sram_gw_n),
      .sram_oe_n(sram_oe_n)
   );

   always #5 clk = ~clk;

   // SSRAM model: data for an address presented with OE appears two cycles later.
   logic [DW-1:0] mem [64];
   logic [AW-1:0] a1, a2;
   logic          oe1, oe2;
   always @(posedge clk) begin
      a1  <= sram_addr;
      a2  <= a1;
      oe1 <= ~sram_oe_n;
      oe2 <= oe1;
   end
   assign sram_rd = oe2 ? mem[a2] : 32'h0BAD0BAD;

   typedef struct {
      int          core;
      bit          rd;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int oe_low, gw_low, busy_cnt, last_oe, last_gw, last_done;
   logic [AW-1:0] gw_addr;
   logic [DW-1:0] gw_wd;
   logic [NC-1:0] hold;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_op(input int c, input bit rd, input logic [31:0] d);
      exp_t e;
      e.core = c;
      e.rd   = rd;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic set_op(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[c]             = w;
      addr[c*AW +: AW]  = a;
      wdata[c*DW +: DW] = d;
   endtask

   task automatic clr_counters();
      oe_low = 0; gw_low = 0; busy_cnt = 0;
      last_oe = -1; last_gw = -1; last_done = -1;
   endtask

   // One cycle: sample at the falling edge, score any completion, then release the finished core.
   task automatic step();
      exp_t          e;
      logic [NC-1:0] exp_stall;
      int            rel;
      @(negedge clk);
      cyc++;
      rel = -1;
      if (!sram_oe_n) begin oe_low++; last_oe = cyc; end
      if (!sram_gw_n) begin gw_low++; last_gw = cyc; gw_addr = sram_addr; gw_wd = sram_wd; end
      if (busy) busy_cnt++;
      exp_stall = req;
      if (done !== '0) begin
         last_done = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("done_onehot", 64'(done), 64'(4'(1) << e.core));
            chk("done_grant_id", 64'(grant_id), 64'(e.core));
            if (e.rd) chk("rdata", 64'(rdata), 64'(e.data));
            exp_stall = req & ~(4'(1) << e.core);
            if (!hold[e.core]) rel = e.core;
         end
      end
      chk("stall", 64'(stall), 64'(exp_stall));
      if (rel >= 0) req[rel] = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", {62'd0, sb.size() != 0, busy}, 64'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      hold    = '0;
      sb.delete();
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      int n;
      bit v_gw, v_oe, v_busy, v_done;
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 + 32'(i);
      mem[5] = 32'hDEADBEEF;
      we = '0; addr = '0; wdata = '0;
      clr_counters();
      do_reset();

      // Reset values
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_addr", 64'(sram_addr), 64'd0);
      chk("rst_wd", 64'(sram_wd), 64'd0);
      chk("rst_gw_n", 64'(sram_gw_n), 64'd1);
      chk("rst_oe_n", 64'(sram_oe_n), 64'd1);
      chk("rst_grant", 64'(grant_id), 64'd0);

      // 1: core0 read of 0x05; operand change after the latch must not matter
      clr_counters();
      set_op(0, 1'b0, 6'h05, 32'h0);
      req[0] = 1'b1;
      expect_op(0, 1'b1, 32'hDEADBEEF);
      step();
      addr[0*AW +: AW] = 6'h06;
      wait_empty(20);
      chk("t1_oe_low", 64'(oe_low), 64'd3);
      chk("t1_gw_low", 64'(gw_low), 64'd0);
      chk("t1_busy_cycles", 64'(busy_cnt), 64'd4);
      chk("t1_done_after_oe", 64'(last_done), 64'(last_oe + 1));

      // 2: core1 write; req dropped mid-transaction still completes
      clr_counters();
      set_op(1, 1'b1, 6'h3F, 32'h12345678);
      req[1] = 1'b1;
      expect_op(1, 1'b0, 32'h0);
      step();
      req[1] = 1'b0;
      wdata[1*DW +: DW] = 32'hFFFFFFFF;
      wait_empty(20);
      chk("t2_gw_low", 64'(gw_low), 64'd1);
      chk("t2_oe_low", 64'(oe_low), 64'd0);
      chk("t2_gw_addr", 64'(gw_addr), 64'h3F);
      chk("t2_gw_wd", 64'(gw_wd), 64'h12345678);
      chk("t2_done_after_gw", 64'(last_done), 64'(last_gw + 1));
      chk("t2_busy_cycles", 64'(busy_cnt), 64'd2);
      chk("t2_rdata_hold", 64'(rdata), 64'hDEADBEEF);

      // 3: all four cores read after reset; then core0 and core1 together -> core0 first (wrap)
      do_reset();
      for (int c = 0; c < NC; c++) begin
         set_op(c, 1'b0, 6'(8 + c), 32'h0);
         expect_op(c, 1'b1, 32'hC0DE0008 + 32'(c));
      end
      req = 4'b1111;
      n = 0;
      while (!(busy && grant_id == 2'd3) && n < 60) begin step(); n++; end
      chk("t3_reach_core3", 64'(busy && grant_id == 2'd3), 64'd1);
      set_op(0, 1'b0, 6'h20, 32'h0);
      set_op(1, 1'b0, 6'h21, 32'h0);
      req[0] = 1'b1;
      req[1] = 1'b1;
      expect_op(0, 1'b1, 32'hC0DE0020);
      expect_op(1, 1'b1, 32'hC0DE0021);
      wait_empty(60);

      // 4: core0 requests continuously, core2 once -> core2 served after one core0 access
      hold[0] = 1'b1;
      set_op(0, 1'b1, 6'h30, 32'hA0A0A0A0);
      req[0] = 1'b1;
      expect_op(0, 1'b0, 32'h0);
      n = 0;
      while (!busy && n < 10) begin step(); n++; end
      chk("t4_core0_granted", 64'(busy && grant_id == 2'd0), 64'd1);
      set_op(2, 1'b0, 6'h31, 32'h0);
      req[2] = 1'b1;
      expect_op(2, 1'b1, 32'hC0DE0031);
      expect_op(0, 1'b0, 32'h0);
      n = 0;
      while (sb.size() > 1 && n < 40) begin step(); n++; end
      chk("t4_core2_served", 64'(sb.size()), 64'd1);
      hold[0] = 1'b0;
      wait_empty(40);

      // 5: reset during WAIT of a core3 read, then the held request completes
      do_reset();
      set_op(3, 1'b0, 6'h10, 32'h0);
      req[3] = 1'b1;
      expect_op(3, 1'b1, 32'hC0DE0010);
      step();
      step();
      chk("t5_in_wait", {62'd0, busy, sram_oe_n}, {62'd0, 1'b1, 1'b0});
      chk("t5_pre_grant", 64'(grant_id), 64'd3);
      chk("t5_pre_rdata", 64'(rdata), 64'd0);
      sb.delete();
      reset_n = 1'b0;
      step();
      chk("t5_oe_n", 64'(sram_oe_n), 64'd1);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_grant", 64'(grant_id), 64'd0);
      chk("t5_rdata", 64'(rdata), 64'd0);
      reset_n = 1'b1;
      expect_op(3, 1'b1, 32'hC0DE0010);
      wait_empty(20);

      // 6: idle for 100 cycles
      req = '0;
      v_gw = 0; v_oe = 0; v_busy = 0; v_done = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (sram_gw_n !== 1'b1) v_gw = 1;
         if (sram_oe_n !== 1'b1) v_oe = 1;
         if (busy !== 1'b0) v_busy = 1;
         if (done !== '0) v_done = 1;
      end
      chk("t6_gw_n_idle", 64'(v_gw), 64'd0);
      chk("t6_oe_n_idle", 64'(v_oe), 64'd0);
      chk("t6_busy_idle", 64'(v_busy), 64'd0);
      chk("t6_done_idle", 64'(v_done), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
